// File: rtl/cordic_rotator_if.sv
// Handshake and operand bundle for the iterative CORDIC rotator.
// The host drives start and the operands; the core returns the result.
interface cordic_rotator_if #(
  parameter int W = 12
);
  logic                start;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] z_in;
  logic                busy;
  logic                out_valid;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] z_res;
  logic                ovf;

  modport master (
    output start, x_in, y_in, z_in,
    input  busy, out_valid, x_out, y_out, z_res, ovf
  );

  modport slave (
    input  start, x_in, y_in, z_in,
    output busy, out_valid, x_out, y_out, z_res, ovf
  );
endinterface

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC, W:FXP_SHIFT fixed point, unscaled output.
// One sample per ITER+2 ce-qualified cycles; gain is removed downstream.
module cordic_rotator #(
  parameter int W         = 12,
  parameter int FXP_SHIFT = 10,
  parameter int ITER      = 10
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           ce,
  cordic_rotator_if.slave bus
);

  localparam int XW   = W + 2;
  localparam int ZW   = W + 1;
  localparam int ZLIM = (1608 << FXP_SHIFT) >> 10;
  localparam logic signed [ZW-1:0] ZMAX = ZW'(ZLIM);
  localparam logic signed [ZW-1:0] ZMIN = -ZMAX;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           cnt;
  logic signed [XW-1:0] xr;
  logic signed [XW-1:0] yr;
  logic signed [ZW-1:0] zr;
  logic                 clamp_flag;

  logic signed [ZW-1:0] zext;
  logic signed [ZW-1:0] zcl;
  logic                 zhit;
  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic signed [ZW-1:0] at;
  logic                 dpos;
  logic                 sat_x;
  logic                 sat_y;
  logic [W-1:0]         x_sat;
  logic [W-1:0]         y_sat;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return ZW'(804);
      4'd1:    return ZW'(475);
      4'd2:    return ZW'(251);
      4'd3:    return ZW'(127);
      4'd4:    return ZW'(64);
      4'd5:    return ZW'(32);
      4'd6:    return ZW'(16);
      4'd7:    return ZW'(8);
      4'd8:    return ZW'(4);
      4'd9:    return ZW'(2);
      4'd10:   return ZW'(1);
      default: return '0;
    endcase
  endfunction

  assign bus.busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = ROTATE;
      ROTATE:  if (cnt == 4'(ITER - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    zext = {bus.z_in[W-1], bus.z_in};
    zcl  = zext;
    zhit = 1'b0;
    if (zext > ZMAX) begin
      zcl  = ZMAX;
      zhit = 1'b1;
    end else if (zext < ZMIN) begin
      zcl  = ZMIN;
      zhit = 1'b1;
    end
  end

  // d = +1 when the residual angle is non-negative
  always_comb begin
    xs   = xr >>> cnt;
    ys   = yr >>> cnt;
    at   = atan_lut(cnt);
    dpos = ~zr[ZW-1];
  end

  // Saturate to W bits when the top guard bits disagree with the sign
  always_comb begin
    sat_x = (xr[XW-1:W-1] != {(XW-W+1){xr[XW-1]}});
    sat_y = (yr[XW-1:W-1] != {(XW-W+1){yr[XW-1]}});
    x_sat = sat_x ? {xr[XW-1], {(W-1){~xr[XW-1]}}} : xr[W-1:0];
    y_sat = sat_y ? {yr[XW-1], {(W-1){~yr[XW-1]}}} : yr[W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (ce)  state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      xr            <= '0;
      yr            <= '0;
      zr            <= '0;
      clamp_flag    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.z_res     <= '0;
      bus.ovf       <= 1'b0;
    end else if (ce) begin
      unique case (state)
        IDLE: begin
          bus.out_valid <= 1'b0;
          if (bus.start) begin
            xr         <= {{2{bus.x_in[W-1]}}, bus.x_in};
            yr         <= {{2{bus.y_in[W-1]}}, bus.y_in};
            zr         <= zcl;
            clamp_flag <= zhit;
            cnt        <= '0;
          end
        end
        ROTATE: begin
          xr  <= dpos ? xr - ys : xr + ys;
          yr  <= dpos ? yr + xs : yr - xs;
          zr  <= dpos ? zr - at : zr + at;
          cnt <= cnt + 4'd1;
        end
        DONE: begin
          bus.x_out     <= x_sat;
          bus.y_out     <= y_sat;
          bus.z_res     <= zr[W-1:0];
          bus.ovf       <= sat_x | sat_y | clamp_flag;
          bus.out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed testbench for cordic_rotator with hand-computed expectations.
// Results are compared within small tolerances for truncation error.
module tb_cordic_rotator;

  localparam int W    = 12;
  localparam int ITER = 10;
  localparam int LAT  = ITER + 1;

  logic clock = 1'b0;
  logic reset_n;
  logic ce;

  cordic_rotator_if #(.W(W)) bus ();

  cordic_rotator #(
    .W(W),
    .FXP_SHIFT(10),
    .ITER(ITER)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .ce(ce),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got,
                       input int exp, input int tol);
    n_chk++;
    if (got - exp > tol || exp - got > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)",
               tag, got, exp, tol);
    end
  endtask

  task automatic launch(input int x, input int y, input int z);
    @(negedge clock);
    bus.x_in  = W'(x);
    bus.y_in  = W'(y);
    bus.z_in  = W'(z);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!bus.out_valid && n < 60);
  endtask

  task automatic run_op(input string tag, input int x, input int y,
                        input int z, input int ex, input int ey,
                        input int tol, input int eovf);
    int n;
    launch(x, y, z);
    check({tag, "_busy"}, int'(bus.busy), 1, 0);
    wait_valid(0, n);
    check({tag, "_lat"}, n, LAT, 0);
    check({tag, "_x"}, int'(bus.x_out), ex, tol);
    check({tag, "_y"}, int'(bus.y_out), ey, tol);
    check({tag, "_ovf"}, int'(bus.ovf), eovf, 0);
    @(posedge clock);
    #1;
    check({tag, "_vdrop"}, int'(bus.out_valid), 0, 0);
    check({tag, "_idle"}, int'(bus.busy), 0, 0);
  endtask

  initial begin
    int n;
    int t1;
    int seen;
    reset_n   = 1'b0;
    ce        = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    bus.z_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", int'(bus.busy), 0, 0);
    check("rst_valid", int'(bus.out_valid), 0, 0);
    check("rst_x", int'(bus.x_out), 0, 0);
    check("rst_y", int'(bus.y_out), 0, 0);
    check("rst_z", int'(bus.z_res), 0, 0);
    check("rst_ovf", int'(bus.ovf), 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("z0", 1024, 0, 0, 1686, 0, 3, 0);
    run_op("z45", 1024, 0, 804, 1192, 1192, 3, 0);
    check("z45_zres", int'(bus.z_res), 0, 2);
    run_op("zp90", 1024, 0, 1608, 0, 1686, 3, 0);
    run_op("zn90", 1024, 0, -1608, 0, -1686, 3, 0);
    run_op("sat", 1600, 1600, 0, 2047, 2047, 0, 1);
    run_op("clamp", 1024, 0, 2000, 0, 1686, 3, 1);

    // start while busy at E3 must be ignored
    launch(1024, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    bus.z_in  = W'(804);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    wait_valid(3, n);
    check("busy_start_lat", n, LAT, 0);
    check("busy_start_x", int'(bus.x_out), 1686, 3);
    check("busy_start_y", int'(bus.y_out), 0, 3);
    seen = 0;
    repeat (15) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) seen = 1;
    end
    check("busy_start_noq", seen, 0, 0);

    // ce low for 5 cycles mid-rotation
    launch(1024, 0, 804);
    repeat (3) @(posedge clock);
    @(negedge clock);
    ce = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    ce = 1'b1;
    wait_valid(8, n);
    check("ce_lat", n, LAT + 5, 0);
    check("ce_x", int'(bus.x_out), 1192, 3);
    check("ce_y", int'(bus.y_out), 1192, 3);
    @(negedge clock);
    ce = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("ce_hold_valid", int'(bus.out_valid), 1, 0);
    check("ce_hold_x", int'(bus.x_out), 1192, 3);
    @(negedge clock);
    ce = 1'b1;
    @(posedge clock);
    #1;
    check("ce_valid_drop", int'(bus.out_valid), 0, 0);

    // asynchronous reset at E4 aborts the operation
    launch(1024, 0, 0);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", int'(bus.busy), 0, 0);
    check("arst_x", int'(bus.x_out), 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) seen = 1;
    end
    check("arst_novalid", seen, 0, 0);

    // start held high: back-to-back operations
    @(negedge clock);
    bus.x_in  = W'(1024);
    bus.y_in  = '0;
    bus.z_in  = '0;
    bus.start = 1'b1;
    @(posedge clock);
    wait_valid(0, n);
    check("b2b_lat1", n, LAT, 0);
    t1 = n;
    wait_valid(n, n);
    @(negedge clock);
    bus.start = 1'b0;
    check("b2b_period", n - t1, ITER + 2, 0);
    check("b2b_x", int'(bus.x_out), 1686, 3);
    repeat (3) @(posedge clock);
    #1;
    check("b2b_idle", int'(bus.busy), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
